// File: rtl/mode_sel_pkg.sv
// Shared types for the multi-channel mode selector.
// MODE_SEL_LOCK_EN enables the long-press lock state.
package mode_sel_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
`ifdef MODE_SEL_LOCK_EN
    S_LOCKED  = 2'd2,
`endif
    S_BLOCK   = 2'd3
  } mode_sel_state_t;

  // Next index in the cyclic sequence 0..modes-1.
  function automatic int unsigned next_mode(input int unsigned cur, input int unsigned modes);
    return (cur == modes - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/mode_sel_if.sv
// Bundle of per-channel button inputs and mode outputs for mode_sel.
// p and r are plain levels sampled every clk edge; there is no valid/ready handshake.
interface mode_sel_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MW       = 2,
  parameter int unsigned CW       = 4
);
  logic [CHANNELS-1:0]    p;
  logic [CHANNELS-1:0]    r;
  logic [CHANNELS*MW-1:0] mode;
  logic [CHANNELS-1:0]    m;
  logic [CHANNELS-1:0]    locked;
  logic [CHANNELS-1:0]    changed;
  logic [CHANNELS*2-1:0]  state_dbg;
  logic [CHANNELS*CW-1:0] cnt_dbg;

  modport master (
    output p, r,
    input  mode, m, locked, changed, state_dbg, cnt_dbg
  );

  modport slave (
    input  p, r,
    output mode, m, locked, changed, state_dbg, cnt_dbg
  );
endinterface

// File: rtl/mode_sel_chan.sv
// One mode-selector channel: FSM, mode register, hold counter and change pulse.
// MODE_SEL_LOCK_EN adds the hold counter driven S_LOCKED state.
module mode_sel_chan
  import mode_sel_pkg::*;
#(
  parameter int unsigned MODES = 4,
  parameter int unsigned HOLD  = 8,
  localparam int unsigned MW   = (MODES > 1) ? $clog2(MODES) : 1,
  localparam int unsigned CW   = $clog2(HOLD + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p,
  input  logic            r,
  output logic [MW-1:0]   mode,
  output logic            locked,
  output logic            changed,
  output mode_sel_state_t state_dbg,
  output logic [CW-1:0]   cnt_dbg
);

  mode_sel_state_t state_q, state_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic            changed_q, changed_d;
  logic [MW-1:0]   mode_inc;

  assign mode_inc = MW'(next_mode(int'(mode_q), MODES));

`ifdef MODE_SEL_LOCK_EN
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
`ifdef MODE_SEL_LOCK_EN
    cnt_d   = cnt_q;
`endif
    if (r) begin
      // Clear wins; a still-held press must be released before it counts again.
      mode_d  = '0;
      state_d = p ? S_BLOCK : S_IDLE;
`ifdef MODE_SEL_LOCK_EN
      cnt_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (p) begin
            mode_d  = mode_inc;
            state_d = S_PRESSED;
`ifdef MODE_SEL_LOCK_EN
            cnt_d   = CW'(1);
`endif
          end
        end
        S_PRESSED: begin
          if (!p) begin
            state_d = S_IDLE;
`ifdef MODE_SEL_LOCK_EN
            cnt_d   = '0;
`endif
          end else begin
`ifdef MODE_SEL_LOCK_EN
            if (cnt_q != CW'(HOLD)) cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(HOLD - 1)) state_d = S_LOCKED;
`endif
          end
        end
`ifdef MODE_SEL_LOCK_EN
        S_LOCKED: begin
          state_d = S_LOCKED;
        end
`endif
        S_BLOCK: begin
          if (!p) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    changed_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      changed_q <= changed_d;
    end
  end

`ifdef MODE_SEL_LOCK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign locked  = (state_q == S_LOCKED);
  assign cnt_dbg = cnt_q;
`else
  assign locked  = 1'b0;
  assign cnt_dbg = '0;
`endif

  assign mode      = mode_q;
  assign changed   = changed_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/mode_sel.sv
// Multi-channel mode selector: CHANNELS independent mode_sel_chan instances.
// Long-press lock is built only when MODE_SEL_LOCK_EN is defined.
module mode_sel
  import mode_sel_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODES    = 4,
  parameter int unsigned HOLD     = 8,
  localparam int unsigned MW      = (MODES > 1) ? $clog2(MODES) : 1,
  localparam int unsigned CW      = $clog2(HOLD + 1)
) (
  input  logic      clk,
  input  logic      reset,
  mode_sel_if.slave bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [MW-1:0]   mode_w;
    logic            locked_w;
    logic            changed_w;
    mode_sel_state_t state_w;
    logic [CW-1:0]   cnt_w;

    mode_sel_chan #(
      .MODES (MODES),
      .HOLD  (HOLD)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .p         (bus.p[i]),
      .r         (bus.r[i]),
      .mode      (mode_w),
      .locked    (locked_w),
      .changed   (changed_w),
      .state_dbg (state_w),
      .cnt_dbg   (cnt_w)
    );

    assign bus.mode[i*MW +: MW]     = mode_w;
    assign bus.m[i]                 = |mode_w;
    assign bus.locked[i]            = locked_w;
    assign bus.changed[i]           = changed_w;
    assign bus.state_dbg[i*2 +: 2]  = state_w;
    assign bus.cnt_dbg[i*CW +: CW]  = cnt_w;
  end

endmodule

// File: tb/tb_mode_sel.sv
// Self-checking bench for mode_sel (CHANNELS=4, MODES=3, HOLD=4), lock on or off.
// Follows MODE_SEL_LOCK_EN in the same way as the RTL build.
module tb_mode_sel;

  localparam int CH    = 4;
  localparam int MODES = 3;
  localparam int HOLD  = 4;
  localparam int MW    = 2;
  localparam int CW    = 3;
`ifdef MODE_SEL_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  mode_sel_if #(.CHANNELS(CH), .MW(MW), .CW(CW)) bus ();

  mode_sel #(.CHANNELS(CH), .MODES(MODES), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: mode index, length of current high run, lock flag, wait-for-release flag
  int md  [CH];
  int run [CH];
  bit lk  [CH];
  bit wr  [CH];
  bit chg [CH];

  int n_checks = 0;
  int n_fail   = 0;
  logic [CH*MW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      md[c] = 0; run[c] = 0; lk[c] = 0; wr[c] = 0; chg[c] = 0;
    end
  endfunction

  function automatic void model_step(input logic [CH-1:0] pv, input logic [CH-1:0] rv);
    for (int c = 0; c < CH; c++) begin
      int prev;
      prev = md[c];
      if (rv[c]) begin
        md[c] = 0; run[c] = 0; lk[c] = 0; wr[c] = pv[c];
      end else if (lk[c]) begin
        // frozen until cleared
      end else if (wr[c]) begin
        if (!pv[c]) wr[c] = 0;
      end else if (pv[c]) begin
        if (run[c] == 0) md[c] = (md[c] + 1) % MODES;
        run[c]++;
        if (LOCK_EN && run[c] >= HOLD) lk[c] = 1;
      end else begin
        run[c] = 0;
      end
      chg[c] = (md[c] != prev);
    end
  endfunction

  task automatic compare_all();
    logic [CH*MW-1:0] exp_v;
    logic [CH*MW-1:0] e;
    exp_v = '0;
    for (int c = 0; c < CH; c++) exp_v[c*MW +: MW] = MW'(md[c]);
    exp_q.push_back(exp_v);
    e = exp_q.pop_front();
    check("mode_vec", 32'(bus.mode), 32'(e));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ch%0d_m", c),       32'(bus.m[c]),       32'(md[c] != 0));
      check($sformatf("ch%0d_locked", c),  32'(bus.locked[c]),  32'(lk[c]));
      check($sformatf("ch%0d_changed", c), 32'(bus.changed[c]), 32'(chg[c]));
    end
  endtask

  // driver: apply inputs, take one edge, advance model, compare
  task automatic cyc(input logic [CH-1:0] pv, input logic [CH-1:0] rv);
    bus.p = pv;
    bus.r = rv;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else       model_step(pv, rv);
    compare_all();
  endtask

  function automatic int dut_mode(input int c);
    return int'(bus.mode[c*MW +: MW]);
  endfunction

  initial begin
    int seq [3];
    logic [CH-1:0] pr;
    seq = '{1, 2, 0};
    reset = 1'b1;
    bus.p = '0;
    bus.r = '0;
    model_reset();

    // reset with random inputs
    repeat (3) cyc(CH'($urandom_range(0, 15)), CH'($urandom_range(0, 15)));
    check("rst_mode", 32'(bus.mode), 32'd0);
    reset = 1'b0;
    repeat (2) cyc('0, '0);
    check("post_rst_mode", 32'(bus.mode), 32'd0);

    // cycling on ch0
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0001, '0);
      check("cyc_mode0", 32'(dut_mode(0)), 32'(seq[k]));
      check("cyc_chg0", 32'(bus.changed[0]), 32'd1);
      repeat (2) cyc('0, '0);
    end

    // lock and clear on ch1
    repeat (6) cyc(4'b0010, '0);
    check("lock_mode1", 32'(dut_mode(1)), 32'd1);
    check("lock_locked1", 32'(bus.locked[1]), 32'(LOCK_EN));
    cyc('0, '0);
    repeat (2) begin
      cyc(4'b0010, '0);
      cyc('0, '0);
    end
    cyc('0, 4'b0010);
    check("clr_mode1", 32'(dut_mode(1)), 32'd0);
    check("clr_locked1", 32'(bus.locked[1]), 32'd0);
    cyc('0, '0);

    // simultaneous p/r on ch2
    repeat (2) begin
      cyc(4'b0100, '0);
      cyc('0, '0);
    end
    check("pre_sim_mode2", 32'(dut_mode(2)), 32'd2);
    cyc(4'b0100, 4'b0100);
    repeat (3) cyc(4'b0100, '0);
    check("sim_mode2", 32'(dut_mode(2)), 32'd0);
    cyc('0, '0);
    cyc(4'b0100, '0);
    check("sim_next_mode2", 32'(dut_mode(2)), 32'd1);
    cyc('0, '0);
    cyc('0, 4'b1111);
    cyc('0, '0);

    // reset mid-hold, all channels
    repeat (2) cyc(4'b1111, '0);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    cyc(4'b1111, '0);
    reset = 1'b0;
    cyc(4'b1111, '0);
    for (int c = 0; c < CH; c++) check("mid_rst_mode", 32'(dut_mode(c)), 32'd1);
    repeat (2) cyc(4'b1111, '0);
    check("mid_rst_nolock", 32'(bus.locked), 32'd0);
    cyc(4'b1111, '0);
    check("mid_rst_lock", 32'(bus.locked), LOCK_EN ? 32'hF : 32'h0);

    // long hold on ch0 after a clear, then release and press
    cyc('0, 4'b1111);
    repeat (10) cyc(4'b0001, '0);
    check("hold_mode0", 32'(dut_mode(0)), 32'd1);
    cyc('0, '0);
    cyc(4'b0001, '0);
    check("hold_next_mode0", 32'(dut_mode(0)), LOCK_EN ? 32'd1 : 32'd2);
    cyc('0, 4'b1111);

    // randomized phase
    pr = '0;
    for (int n = 0; n < 600; n++) begin
      logic [CH-1:0] rr;
      rr = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 3) == 0) pr[c] = ~pr[c];
        rr[c] = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 149) == 0) reset = 1'b1;
      else                              reset = 1'b0;
      cyc(pr, rr);
    end
    reset = 1'b0;
    cyc('0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_sel.md
# mode_sel

Multi-channel, parametrised mode selector: each of `CHANNELS` independent channels cycles through `MODES` modes on press events and returns to mode 0 on release/clear. An optional long-press lock freezes a channel's mode until it is cleared. The block sits between the synchronised push-button inputs and the downstream mode-dependent datapath. It replaces the single-channel two-state press/release mode flag.

## Interface
- `CHANNELS`, 4, number of independent channels (>=1)
- `MODES`, 4, modes per channel (>=2); `MW = $clog2(MODES)`
- `HOLD`, 8, consecutive sampled-high cycles of `p` that trigger lock (>=2)
- `clk`  input  1  single clock; all state updates on its rising edge
- `reset`  input  1  asynchronous, active-high reset
- `p`  input  CHANNELS  press request per channel, level, synchronous to `clk`
- `r`  input  CHANNELS  release/clear per channel, level, synchronous to `clk`
- `mode`  output  CHANNELS*MW  current mode index; channel i occupies bits [i*MW +: MW]
- `m`  output  CHANNELS  `mode[i] != 0`
- `locked`  output  CHANNELS  channel is in the lock state
- `changed`  output  CHANNELS  one-cycle pulse: `mode[i]` differs from its previous-cycle value

## Operation
- Per-channel FSM states: S_IDLE, S_PRESSED, S_LOCKED, S_BLOCK. Per-channel hold counter, width `$clog2(HOLD+1)`, saturating at HOLD.
- `r[i]=1` has priority in every state: mode <= 0, counter <= 0, state <= S_BLOCK if `p[i]=1`, else S_IDLE.
- S_IDLE, `p=1`: mode <= (mode == MODES-1) ? 0 : mode+1; counter <= 1; go S_PRESSED. `p=0`: stay.
- S_PRESSED, `p=0`: counter <= 0; go S_IDLE. `p=1`: counter increments. When the counter reaches HOLD (HOLD consecutive sampled-high cycles including the first), go S_LOCKED. No further mode advance while in this state.
- S_LOCKED: `p` ignored. Only `r` leaves the state.
- S_BLOCK: the press is ignored until `p=0`, then go S_IDLE with no mode change. This prevents a held button advancing the mode immediately after a clear.
- Outputs are registered/derived from registers only: `locked[i] = (state == S_LOCKED)`; `m` is combinational from the `mode` register.
- `changed[i]` is registered and asserts in the same cycle the new `mode[i]` value is visible. A clear while mode is already 0 produces no pulse.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (async assert, sync release by the environment): all states S_IDLE, counters 0; `mode`, `m`, `locked`, `changed` all 0.
- Press latency: `p` sampled high at edge k -> `mode` updated after edge k; `changed` high for the cycle following edge k.
- Lock latency: `p` high at edges k..k+HOLD-1 -> `locked` high after edge k+HOLD-1.
- Clear latency: `r` sampled at edge k -> `mode`=0 and `locked`=0 after edge k.
- Reset mid-operation discards counters and lock. If `p` is still high at the first edge after reset release, the channel treats it as a new press and advances.
- Wrap-around: the mode sequence is 0,1,…,MODES-1,0. For non-power-of-two MODES, index values >= MODES are never produced.

## Configuration
- `MODE_SEL_LOCK_EN` defined: long-press lock as above.
- Not defined:
  - S_LOCKED is not compiled and S_PRESSED never exits on the counter.
  - The hold counter is removed.
  - `locked` is tied to 0; the port is retained.
  - All other behaviour is identical.

## Structure
- Package `mode_sel_pkg`: the state enum typedef (`mode_sel_state_t`) and the state encodings.
- Sub-module `mode_sel_chan`: one channel (FSM, mode register, counter, changed register), parametrised by MODES/HOLD.
- The top level instantiates `mode_sel_chan` in a generate loop and packs `mode`.

## Test plan
All scenarios use CHANNELS=4, MODES=3, HOLD=4, macro defined unless noted.
- Reset: assert `reset` with random `p`/`r` -> `mode`=0, `m`=0, `locked`=0, `changed`=0. Release with all inputs low -> outputs stay 0.
- Cycling: ch0 three 1-cycle `p` pulses separated by 2 idle cycles -> `mode[0]` 1,2,0; `changed[0]` one pulse each; `m[0]` 1,1,0.
- Lock and clear: ch1 `p` held 6 cycles -> `mode[1]`=1 after the 1st edge, `locked[1]`=1 after the 4th edge. Further `p` pulses leave `mode[1]`=1. A 1-cycle `r[1]` -> `mode[1]`=0, `locked[1]`=0, one `changed[1]` pulse.
- Simultaneous `p`/`r`: ch2 at mode 2, `p` and `r` high together, `p` held 3 more cycles -> `mode[2]`=0 with no advance while `p` stays high. The next press after `p` low -> `mode[2]`=1.
- Reset mid-hold with channel independence: all four channels pressed together, reset asserted on the 2nd hold cycle with `p` still high after release -> all outputs 0 during reset, each mode 1 after the first post-reset edge, no `locked` until 4 further high cycles.
- Macro undefined: ch0 `p` held 10 cycles -> a single advance to 1, `locked` stays 0; release then press -> mode 2.
